// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: state encoding and
// default frame parameters, so benches and integrators can decode state.
package program_loader_pkg;

   typedef enum logic [2:0] {
      ST_SYNC   = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_LEN_LO = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERROR  = 3'd6
   } state_e;

   localparam int         ADDR_W_DEFAULT    = 8;
   localparam int         DEPTH_DEFAULT     = 256;
   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/program_loader.sv
// Boot-time loader: parses SYNC/LEN_HI/LEN_LO/payload/CSUM frames from a
// valid/ready byte stream, writes the payload into instruction memory from
// address 0, and holds the CPU in reset until a checksum-verified image is in.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int         ADDR_W    = ADDR_W_DEFAULT,
   parameter int         DEPTH     = DEPTH_DEFAULT,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [7:0]        imem_wdata,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              load_error
);

   // One extra bit so a full-size image (LEN == 2**ADDR_W) does not wrap.
   localparam int              CNT_W     = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [15:0]     DEPTH_LEN = 16'(DEPTH);

   state_e             state_q,     state_d;
   logic [7:0]         len_hi_q,    len_hi_d;
   logic [CNT_W-1:0]   len_q,       len_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic [7:0]         acc_q,       acc_d;
   logic               we_q,        we_d;
   logic [ADDR_W-1:0]  addr_q,      addr_d;
   logic [7:0]         wdata_q,     wdata_d;
   logic               cpu_reset_q, cpu_reset_d;
   logic               done_q,      done_d;
   logic               error_q,     error_d;

   logic               xfer;
   logic [15:0]        len_full;
   logic [CNT_W-1:0]   cnt_inc;

   // The loader never back-pressures upstream.
   assign in_ready = 1'b1;
   assign xfer     = in_valid & in_ready;
   assign len_full = {len_hi_q, in_data};
   assign cnt_inc  = cnt_q + CNT_ONE;

   // Next-state and next-datapath decode for every accepted byte.
   always_comb begin
      // NOTE: every _d gets its hold/idle value first, so no path infers a latch.
      state_d     = state_q;
      len_hi_d    = len_hi_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_reset_d = cpu_reset_q;
      done_d      = done_q;
      error_d     = error_q;

      if (xfer) begin
         case (state_q)
            // A sync byte opens a fresh frame from any idle/terminal state.
            ST_SYNC, ST_DONE, ST_ERROR: begin
               if (in_data == SYNC_BYTE) begin
                  state_d     = ST_LEN_HI;
                  cpu_reset_d = 1'b1;
                  done_d      = 1'b0;
                  error_d     = 1'b0;
                  cnt_d       = '0;
                  acc_d       = '0;
               end
            end
            ST_LEN_HI: begin
               len_hi_d = in_data;
               state_d  = ST_LEN_LO;
            end
            ST_LEN_LO: begin
               len_d = CNT_W'(len_full);
               if (len_full[0] || (len_full > DEPTH_LEN)) begin
                  state_d = ST_ERROR;
                  error_d = 1'b1;
               end else if (len_full == 16'd0) begin
                  state_d = ST_CSUM;
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               we_d    = 1'b1;
               addr_d  = cnt_q[ADDR_W-1:0];
               wdata_d = in_data;
               acc_d   = acc_q + in_data;
               cnt_d   = cnt_inc;
               if (cnt_inc == len_q) begin
                  state_d = ST_CSUM;
               end
            end
            ST_CSUM: begin
               if (in_data == acc_q) begin
                  state_d     = ST_DONE;
                  cpu_reset_d = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  state_d = ST_ERROR;
                  error_d = 1'b1;
               end
            end
            default: state_d = ST_SYNC;
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential blocks use <= so every flop samples pre-edge values.
      if (reset) begin
         state_q <= ST_SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   // Registered datapath: length, counter, checksum, memory write port, status.
   always_ff @(posedge clk) begin
      // NOTE: only these control/datapath flops reset; the instruction memory
      // they feed is never cleared, so a rejected image stays resident but unused.
      if (reset) begin
         len_hi_q    <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         len_hi_q    <= len_hi_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_reset_q <= cpu_reset_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_reset  = cpu_reset_q;
   assign load_done  = done_q;
   assign load_error = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a frame-level reference model (position within the
// current frame's byte list) predicts every output each cycle; directed frames
// pin the model with literal expectations, then randomized frames follow.
module tb_program_loader;
   import program_loader_pkg::*;

   localparam int         ADDR_W = 8;
   localparam int         DEPTH  = 256;
   localparam logic [7:0] SYNC   = 8'hA5;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [7:0]        imem_wdata;
   logic              cpu_reset;
   logic              load_done;
   logic              load_error;

   program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .load_done  (load_done),
      .load_error (load_error)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Instruction memory stand-in, written only through the loader's port.
   logic [7:0] tb_mem [DEPTH];
   int         wr_cnt = 0;
   always @(posedge clk) begin
      if (imem_we === 1'b1) begin
         tb_mem[imem_addr] <= imem_wdata;
         wr_cnt = wr_cnt + 1;
      end
   end

   // Reference model: bytes of the frame in progress after its sync byte.
   bit          m_seen_reset = 1'b0;
   bit          m_active     = 1'b0;
   logic [7:0]  m_fb [$];
   logic        m_we = 1'b0;
   logic [7:0]  m_addr = 8'h00;
   logic [7:0]  m_wdata = 8'h00;
   logic        m_cpu_reset = 1'b1;
   logic        m_done = 1'b0;
   logic        m_err = 1'b0;
   logic [7:0]  m_mem [DEPTH];
   int          m_n, m_len, m_sum;

   always @(posedge clk) begin
      m_we = 1'b0;
      if (reset) begin
         m_seen_reset = 1'b1;
         m_active     = 1'b0;
         m_fb.delete();
         m_cpu_reset  = 1'b1;
         m_done       = 1'b0;
         m_err        = 1'b0;
      end else if (in_valid) begin
         if (!m_active) begin
            if (in_data == SYNC) begin
               m_active    = 1'b1;
               m_fb.delete();
               m_cpu_reset = 1'b1;
               m_done      = 1'b0;
               m_err       = 1'b0;
            end
         end else begin
            m_fb.push_back(in_data);
            m_n   = m_fb.size();
            m_len = (m_n >= 2) ? (int'(m_fb[0]) * 256 + int'(m_fb[1])) : -1;
            if (m_n == 2 && ((m_len % 2) != 0 || m_len > DEPTH)) begin
               m_err    = 1'b1;
               m_active = 1'b0;
            end else if (m_n >= 3 && m_n <= m_len + 2) begin
               m_we           = 1'b1;
               m_addr         = 8'(m_n - 3);
               m_wdata        = in_data;
               m_mem[m_n - 3] = in_data;
            end else if (m_n >= 3 && m_n == m_len + 3) begin
               m_sum = 0;
               for (int i = 2; i < m_n - 1; i++) m_sum += int'(m_fb[i]);
               if (8'(m_sum) == in_data) begin
                  m_done      = 1'b1;
                  m_cpu_reset = 1'b0;
               end else begin
                  m_err = 1'b1;
               end
               m_active = 1'b0;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_seen_reset) begin
         check("in_ready", 32'(in_ready), 32'(1'b1));
         check("imem_we", 32'(imem_we), 32'(m_we));
         if (m_we) begin
            check("imem_addr", 32'(imem_addr), 32'(m_addr));
            check("imem_wdata", 32'(imem_wdata), 32'(m_wdata));
         end
         check("cpu_reset", 32'(cpu_reset), 32'(m_cpu_reset));
         check("load_done", 32'(load_done), 32'(m_done));
         check("load_error", 32'(load_error), 32'(m_err));
      end
   end

   // Stimulus helpers.
   int         min_gap = 0;
   int         max_gap = 0;
   logic [7:0] pay [$];

   task automatic send(input logic [7:0] b);
      int g = $urandom_range(max_gap, min_gap);
      repeat (g) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic send_frame(input logic [7:0] csum_xor);
      logic [7:0] s = 8'h00;
      int len = pay.size();
      send(SYNC);
      send(8'(len >> 8));
      send(8'(len));
      foreach (pay[i]) begin
         send(pay[i]);
         s = s + pay[i];
      end
      send(s ^ csum_xor);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(in_ready), 32'(1'b1));
      check({tag, "_we"}, 32'(imem_we), 32'(1'b0));
      check({tag, "_addr"}, 32'(imem_addr), 32'(0));
      check({tag, "_wdata"}, 32'(imem_wdata), 32'(0));
      check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(1'b1));
      check({tag, "_done"}, 32'(load_done), 32'(1'b0));
      check({tag, "_error"}, 32'(load_error), 32'(1'b0));
   endtask

   task automatic check_frame1_mem(input string tag);
      logic [7:0] exp_img [6] = '{8'hF2, 8'h1E, 8'hF4, 8'h14, 8'h06, 8'h50};
      for (int i = 0; i < 6; i++) check($sformatf("%s_mem%0d", tag, i), 32'(tb_mem[i]), 32'(exp_img[i]));
   endtask

   task automatic load_frame1_payload();
      pay = '{8'hF2, 8'h1E, 8'hF4, 8'h14, 8'h06, 8'h50};
   endtask

   int wr0;

   initial begin
      // Reset state.
      reset = 1'b1;
      idle(3);
      check_reset_outputs("rst");
      reset = 1'b0;
      idle(2);

      // Test 1: good 6-byte image, checksum 6E.
      load_frame1_payload();
      wr0 = wr_cnt;
      send_frame(8'h00);
      idle(2);
      check("t1_done", 32'(load_done), 32'(1'b1));
      check("t1_cpu_reset", 32'(cpu_reset), 32'(1'b0));
      check("t1_error", 32'(load_error), 32'(1'b0));
      check("t1_writes", 32'(wr_cnt - wr0), 32'(6));
      check_frame1_mem("t1");

      // Test 2: same image with checksum 6F.
      send_frame(8'h01);
      idle(2);
      check("t2_error", 32'(load_error), 32'(1'b1));
      check("t2_done", 32'(load_done), 32'(1'b0));
      check("t2_cpu_reset", 32'(cpu_reset), 32'(1'b1));
      check_frame1_mem("t2");

      // Test 3: junk before sync and 1-3 cycle valid gaps throughout.
      reset = 1'b1; idle(1); reset = 1'b0;
      wr0 = wr_cnt;
      min_gap = 1; max_gap = 3;
      send(8'h00); send(8'hFF); send(8'h12);
      send_frame(8'h00);
      min_gap = 0; max_gap = 0;
      idle(2);
      check("t3_done", 32'(load_done), 32'(1'b1));
      check("t3_writes", 32'(wr_cnt - wr0), 32'(6));
      check_frame1_mem("t3");

      // Test 4: odd and oversized lengths fail right after LEN_LO.
      wr0 = wr_cnt;
      send(SYNC); send(8'h00); send(8'h05);
      check("t4_odd_error", 32'(load_error), 32'(1'b1));
      send(SYNC); send(8'h01); send(8'h02);
      check("t4_big_error", 32'(load_error), 32'(1'b1));
      idle(2);
      check("t4_writes", 32'(wr_cnt - wr0), 32'(0));

      // Test 5: reset after three payload bytes, then a clean reload.
      send(SYNC); send(8'h00); send(8'h06);
      send(8'hF2); send(8'h1E); send(8'hF4);
      reset = 1'b1;
      idle(1);
      check_reset_outputs("t5");
      reset = 1'b0;
      load_frame1_payload();
      send_frame(8'h00);
      idle(1);
      check("t5_done", 32'(load_done), 32'(1'b1));
      check_frame1_mem("t5");

      // Test 6: reload over a running image.
      send(SYNC);
      check("t6_cpu_reset_on_sync", 32'(cpu_reset), 32'(1'b1));
      check("t6_done_cleared", 32'(load_done), 32'(1'b0));
      send(8'h00); send(8'h02); send(8'hAA); send(8'hBB); send(8'h65);
      idle(1);
      check("t6_done", 32'(load_done), 32'(1'b1));
      check("t6_mem0", 32'(tb_mem[0]), 32'(8'hAA));
      check("t6_mem1", 32'(tb_mem[1]), 32'(8'hBB));

      // Boundaries: LEN == 0 (good and bad checksum) and LEN == DEPTH.
      pay.delete();
      send_frame(8'h00);
      check("len0_done", 32'(load_done), 32'(1'b1));
      send_frame(8'h01);
      check("len0_error", 32'(load_error), 32'(1'b1));
      pay.delete();
      for (int i = 0; i < DEPTH; i++) pay.push_back(8'($urandom));
      send_frame(8'h00);
      idle(1);
      check("full_done", 32'(load_done), 32'(1'b1));
      for (int i = 0; i < DEPTH; i++) check("full_mem", 32'(tb_mem[i]), 32'(m_mem[i]));

      // Randomized frames, all outcomes checked cycle by cycle by the model.
      for (int it = 0; it < 40; it++) begin
         int kind = $urandom_range(4, 0);
         int len;
         logic [7:0] junk;
         max_gap = $urandom_range(2, 0);
         repeat ($urandom_range(2, 0)) begin
            junk = 8'($urandom);
            if (junk == SYNC) junk = 8'h00;
            send(junk);
         end
         case (kind)
            0, 1: begin
               len = 2 * $urandom_range(32, 0);
               pay.delete();
               for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
               send_frame((kind == 0) ? 8'h00 : 8'($urandom_range(255, 1)));
               idle(1);
               if (kind == 0) begin
                  check("rnd_done", 32'(load_done), 32'(1'b1));
                  for (int i = 0; i < len; i++) check("rnd_mem", 32'(tb_mem[i]), 32'(m_mem[i]));
               end else begin
                  check("rnd_error", 32'(load_error), 32'(1'b1));
               end
            end
            2: begin
               len = 2 * $urandom_range(255, 0) + 1;
               send(SYNC); send(8'(len >> 8)); send(8'(len));
            end
            3: begin
               len = $urandom_range(65535, DEPTH + 1);
               send(SYNC); send(8'(len >> 8)); send(8'(len));
            end
            default: begin
               len = 2 * $urandom_range(32, 1);
               send(SYNC); send(8'(len >> 8)); send(8'(len));
               repeat ($urandom_range(len - 1, 0)) send(8'($urandom));
               reset = 1'b1;
               idle($urandom_range(2, 1));
               reset = 1'b0;
            end
         endcase
      end

      max_gap = 0;
      idle(4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
